chacha_sequencer: RTL and testbench
===================================

# chacha_sequencer

Control sequencer for the ChaCha block engine. It drives the four column quarter-round cores from the initiator side of their shared control bus: it accepts 48 key/counter/nonce bytes on a byte stream, runs the rounds, issues the add-back, then streams the 64-byte keystream block out. It owns all core strobes and addressing; the cores hold the state and do the arithmetic.

## Interface
Parameters:
- `ROUNDS`, default 20: total rounds. Must be even and at least 2; the block runs ROUNDS/2 double rounds.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low; clock clk. Shared with the cores.
- `in_valid` in 1: input byte valid.
- `in_ready` out 1: input byte accepted when `in_valid && in_ready`.
- `in_data` in 8: input byte.
- `out_valid` out 1: keystream byte valid.
- `out_ready` in 1: keystream byte consumed when `out_valid && out_ready`.
- `out_data` out 8: keystream byte.
- `busy` out 1: high during the round, shift and add-back phases.
- `core_write` out 1: byte write strobe to all cores.
- `core_calc` out 1: quarter-round step strobe.
- `core_shift` out 1: row-rotate strobe.
- `core_add_back` out 1: add-initial-state strobe.
- `core_step` out 2: step index for calc and shift.
- `core_addr` out 6: {row[1:0], col[1:0], byte[1:0]}.
- `core_wdata` out 8: write data, equal to `in_data`.
- `core_rdata` in 8: OR of all core `data_out` buses. This input is combinational from `core_addr`.

## Operation
- States: LOAD, COL, DIAG, DROW, UNDIAG, ADD, OUT. The reset state is LOAD, with the byte counter, step counter and round counter all at 0.
- **LOAD**:
  - `in_ready`=1 and `core_addr`=16+cnt.
  - `core_write` = `in_valid`. `cnt` increments on each handshake.
  - Byte order: key[0..31], counter (little-endian), nonce[0..11]. These map to rows 1–3, word-major and little-endian within each word. Row 0 is constant inside the cores and is never written.
  - After handshake 48 (cnt=47), the state goes to COL and cnt clears.
- **COL**: four cycles of `core_calc`=1 with `core_step` 0,1,2,3. Then DIAG.
- **DIAG**: six cycles of `core_shift`=1 with `core_step` 1,2,2,3,3,3. This rotates row b by 1 column, c by 2 and d by 3. Then DROW.
- **DROW**: identical to COL. Then UNDIAG.
- **UNDIAG**: six cycles of `core_shift`=1 with `core_step` 1,1,1,2,2,3. This completes a rotation by 4, which restores column alignment.
  - If fewer than ROUNDS/2 double rounds are done, the next state is COL.
  - Otherwise the next state is ADD.
- **ADD**: one cycle of `core_add_back`=1. Then OUT with cnt=0.
- **OUT**:
  - `out_valid`=1, `core_addr`=cnt (0..63) and `out_data`=`core_rdata`.
  - `cnt` advances on each handshake.
  - After byte 63 is consumed, the state goes to LOAD and cnt clears.
- Strobes are mutually exclusive; at most one of write/calc/shift/add_back is high in any cycle.
- Outside COL, DIAG, DROW and UNDIAG, `core_step`=0. Outside LOAD and OUT, `core_addr`=0.
- `busy` = state ∈ {COL, DIAG, DROW, UNDIAG, ADD}.
- Every core state byte must be rewritten each block. The sequencer has no reload; the next block requires 48 fresh input bytes.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, all core strobes 0, `core_step`=0, `core_addr`=16 (LOAD, cnt=0), `out_data`=`core_rdata`.
- Input: one byte per cycle at full rate. Stalls on `in_valid`=0 hold the state and counter.
- Let T be the cycle of the last input handshake. Then:
  - first `core_calc` at T+1;
  - the phases occupy 20 cycles per double round;
  - `core_add_back` at T+1+10·ROUNDS, which is T+201 for ROUNDS=20;
  - first `out_valid` at T+2+10·ROUNDS.
- Output:
  - `out_data` is combinational from `core_addr`.
  - Back-pressure holds the same byte indefinitely.
  - At full rate a block drains in 64 cycles.
- LOAD is entered the cycle after byte 63 handshakes; `in_ready` is high in that cycle.
- `rst_n` low in any state takes effect at the next edge: the state returns to LOAD with all strobes deasserted. The cores reset in the same cycle, so a partial block is discarded.

## Configuration
- **`CHACHA_SEQ_ABORT_EN` defined**: adds input port `abort` (1 bit).
  - `abort`=1 in any state other than LOAD with cnt=0 returns the block to LOAD with all counters 0 at the next edge.
  - All core strobes are low in that cycle. Any byte offered on that cycle's handshake is dropped.
  - Core contents are not cleared; the next load overwrites rows 1–3.
  - `abort` takes priority over every handshake.
- **`CHACHA_SEQ_ABORT_EN` undefined**: the port does not exist, and a block can only be interrupted by `rst_n`.

## Test plan
- **Reset**: hold `rst_n`=0 for 2 cycles → `in_ready`=1, `out_valid`=0, `busy`=0, all strobes 0, `core_addr`=16.
- **Load addressing**: 48 bytes 0x00..0x2F, with `in_valid` deasserted on bytes 5 and 30 → `core_write` with `core_addr`=16..63 and `core_wdata` equal to the byte each time; no write during the gaps.
- **Strobe sequence, ROUNDS=20**: check the first 20 post-load cycles match calc 0,1,2,3 / shift 1,2,2,3,3,3 / calc 0,1,2,3 / shift 1,1,1,2,2,3. Then exactly 200 calc+shift cycles, add_back at T+201, and `out_valid` at T+202.
- **RFC 8439 §2.3.2 vector, with cores attached**:
  - Stimulus: key 00..1f, counter 01 00 00 00, nonce 00 00 00 09 00 00 00 4a 00 00 00 00.
  - Required: the first 16 output bytes are 10 f1 e7 e4 d1 3b 59 15 50 0f dd 1f a3 20 71 c4, and all 64 bytes match the RFC.
- **Back-pressure**: random `out_ready` with 50% duty → bytes unchanged while stalled, exactly 64 handshakes, then `in_ready`=1 the next cycle.
- **Reset mid-round**: pulse `rst_n` low at T+100 → LOAD at the next edge with strobes low. A subsequent full vector load produces correct output.

Source files
------------

// File: rtl/chacha_sequencer.sv
// Control sequencer for the ChaCha block engine: byte load, column/diagonal rounds,
// add-back and keystream drain. Optional `CHACHA_SEQ_ABORT_EN adds an abort input.
module chacha_sequencer #(
  parameter int ROUNDS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef CHACHA_SEQ_ABORT_EN
  input  logic       abort,
`endif
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy,
  output logic       core_write,
  output logic       core_calc,
  output logic       core_shift,
  output logic       core_add_back,
  output logic [1:0] core_step,
  output logic [5:0] core_addr,
  output logic [7:0] core_wdata,
  input  logic [7:0] core_rdata,
  output logic [2:0] dbg_state
);

  localparam int DR = ROUNDS / 2;
  localparam int RW = (DR > 1) ? $clog2(DR) : 1;

  // Handshakes: a byte moves on a cycle where valid && ready; valid never waits on ready.
  typedef enum logic [2:0] {
    LOAD   = 3'd0,
    COL    = 3'd1,
    DIAG   = 3'd2,
    DROW   = 3'd3,
    UNDIAG = 3'd4,
    ADD    = 3'd5,
    OUT    = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [2:0]    step_q, step_d;
  logic [RW-1:0] round_q, round_d;

  // Each shift strobe rotates one row left by one column.
  function automatic logic [1:0] diag_row(input logic [2:0] i);
    case (i)
      3'd0:       diag_row = 2'd1;
      3'd1, 3'd2: diag_row = 2'd2;
      default:    diag_row = 2'd3;
    endcase
  endfunction

  function automatic logic [1:0] undiag_row(input logic [2:0] i);
    case (i)
      3'd0, 3'd1, 3'd2: undiag_row = 2'd1;
      3'd3, 3'd4:       undiag_row = 2'd2;
      default:          undiag_row = 2'd3;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      step_q  <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    step_d        = step_q;
    round_d       = round_q;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    core_write    = 1'b0;
    core_calc     = 1'b0;
    core_shift    = 1'b0;
    core_add_back = 1'b0;
    core_step     = 2'd0;
    core_addr     = 6'd0;
    case (state_q)
      LOAD: begin
        in_ready   = 1'b1;
        core_addr  = 6'd16 + cnt_q;
        core_write = in_valid;
        if (in_valid) begin
          if (cnt_q == 6'd47) begin
            state_d = COL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      COL, DROW: begin
        core_calc = 1'b1;
        core_step = step_q[1:0];
        if (step_q == 3'd3) begin
          step_d  = '0;
          state_d = (state_q == COL) ? DIAG : UNDIAG;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      DIAG: begin
        core_shift = 1'b1;
        core_step  = diag_row(step_q);
        if (step_q == 3'd5) begin
          step_d  = '0;
          state_d = DROW;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      UNDIAG: begin
        core_shift = 1'b1;
        core_step  = undiag_row(step_q);
        if (step_q == 3'd5) begin
          step_d = '0;
          if (round_q == RW'(DR - 1)) begin
            round_d = '0;
            state_d = ADD;
          end else begin
            round_d = round_q + RW'(1);
            state_d = COL;
          end
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      ADD: begin
        core_add_back = 1'b1;
        cnt_d         = '0;
        state_d       = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        core_addr = cnt_q;
        if (out_ready) begin
          if (cnt_q == 6'd63) begin
            state_d = LOAD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
        step_d  = '0;
        round_d = '0;
      end
    endcase
`ifdef CHACHA_SEQ_ABORT_EN
    // Abort wins over any handshake; core contents are left for the next load to overwrite.
    if (abort && !(state_q == LOAD && cnt_q == 6'd0)) begin
      state_d       = LOAD;
      cnt_d         = '0;
      step_d        = '0;
      round_d       = '0;
      core_write    = 1'b0;
      core_calc     = 1'b0;
      core_shift    = 1'b0;
      core_add_back = 1'b0;
    end
`endif
  end

  assign core_wdata = in_data;
  assign out_data   = core_rdata;
  assign busy       = (state_q == COL) || (state_q == DIAG) || (state_q == DROW) ||
                      (state_q == UNDIAG) || (state_q == ADD);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_chacha_sequencer.sv
// Bench for chacha_sequencer with a behavioural model of the four column cores
// and an independent ChaCha block reference feeding the expected-byte queue.
module tb_chacha_sequencer;
  localparam int ROUNDS = 20;

  logic       clk, rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0] in_data, out_data, core_wdata, core_rdata;
  logic       core_write, core_calc, core_shift, core_add_back;
  logic [1:0] core_step;
  logic [5:0] core_addr;
  logic [2:0] dbg_state;

  chacha_sequencer #(.ROUNDS(ROUNDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .core_write(core_write), .core_calc(core_calc),
    .core_shift(core_shift), .core_add_back(core_add_back),
    .core_step(core_step), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- core model ----------------
  localparam logic [31:0] C0 = 32'h61707865, C1 = 32'h3320646e,
                          C2 = 32'h79622d32, C3 = 32'h6b206574;
  logic [31:0] st[16];
  logic [31:0] init_st[16];

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  always @(posedge clk) begin
    logic [31:0] a, b, cc, d;
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin st[i] <= '0; init_st[i] <= '0; end
      st[0] <= C0; st[1] <= C1; st[2] <= C2; st[3] <= C3;
      init_st[0] <= C0; init_st[1] <= C1; init_st[2] <= C2; init_st[3] <= C3;
    end else if (core_write) begin
      st[core_addr[5:2]][core_addr[1:0]*8 +: 8]      <= core_wdata;
      init_st[core_addr[5:2]][core_addr[1:0]*8 +: 8] <= core_wdata;
      if (core_addr == 6'd16) begin
        st[0] <= C0; st[1] <= C1; st[2] <= C2; st[3] <= C3;
      end
    end else if (core_calc) begin
      for (int c = 0; c < 4; c++) begin
        a = st[c]; b = st[4+c]; cc = st[8+c]; d = st[12+c];
        case (core_step)
          2'd0: begin a = a + b;   d = rotl(d ^ a, 16); end
          2'd1: begin cc = cc + d; b = rotl(b ^ cc, 12); end
          2'd2: begin a = a + b;   d = rotl(d ^ a, 8); end
          default: begin cc = cc + d; b = rotl(b ^ cc, 7); end
        endcase
        st[c] <= a; st[4+c] <= b; st[8+c] <= cc; st[12+c] <= d;
      end
    end else if (core_shift) begin
      for (int c = 0; c < 4; c++)
        st[core_step*4 + c] <= st[core_step*4 + ((c + 1) % 4)];
    end else if (core_add_back) begin
      for (int i = 0; i < 16; i++) st[i] <= st[i] + init_st[i];
    end
  end

  always_comb core_rdata = st[core_addr[5:2]][core_addr[1:0]*8 +: 8];

  // ---------------- reference model and scoreboard ----------------
  logic [7:0]  exp_q[$];
  logic [7:0]  ld_bytes[48];
  logic [31:0] ref_x[16];
  logic [31:0] ref_w[16];
  logic [7:0]  rfc16[16] = '{8'h10, 8'hf1, 8'he7, 8'he4, 8'hd1, 8'h3b, 8'h59, 8'h15,
                             8'h50, 8'h0f, 8'hdd, 8'h1f, 8'ha3, 8'h20, 8'h71, 8'hc4};
  int pat_calc[20] = '{1,1,1,1, 0,0,0,0,0,0, 1,1,1,1, 0,0,0,0,0,0};
  int pat_step[20] = '{0,1,2,3, 1,2,2,3,3,3, 0,1,2,3, 1,1,1,2,2,3};
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic qr(input int a, input int b, input int c, input int d);
    ref_w[a] = ref_w[a] + ref_w[b]; ref_w[d] = rotl(ref_w[d] ^ ref_w[a], 16);
    ref_w[c] = ref_w[c] + ref_w[d]; ref_w[b] = rotl(ref_w[b] ^ ref_w[c], 12);
    ref_w[a] = ref_w[a] + ref_w[b]; ref_w[d] = rotl(ref_w[d] ^ ref_w[a], 8);
    ref_w[c] = ref_w[c] + ref_w[d]; ref_w[b] = rotl(ref_w[b] ^ ref_w[c], 7);
  endtask

  task automatic ref_block_push();
    logic [31:0] v;
    ref_x[0] = C0; ref_x[1] = C1; ref_x[2] = C2; ref_x[3] = C3;
    for (int i = 0; i < 12; i++)
      ref_x[4+i] = {ld_bytes[4*i+3], ld_bytes[4*i+2], ld_bytes[4*i+1], ld_bytes[4*i]};
    for (int i = 0; i < 16; i++) ref_w[i] = ref_x[i];
    for (int r = 0; r < ROUNDS / 2; r++) begin
      qr(0, 4, 8, 12); qr(1, 5, 9, 13); qr(2, 6, 10, 14); qr(3, 7, 11, 15);
      qr(0, 5, 10, 15); qr(1, 6, 11, 12); qr(2, 7, 8, 13); qr(3, 4, 9, 14);
    end
    for (int i = 0; i < 16; i++) begin
      v = ref_w[i] + ref_x[i];
      for (int k = 0; k < 4; k++) exp_q.push_back(v[k*8 +: 8]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_rfc_vector();
    for (int i = 0; i < 32; i++) ld_bytes[i] = 8'(i);
    for (int i = 32; i < 48; i++) ld_bytes[i] = 8'h00;
    ld_bytes[32] = 8'h01; ld_bytes[39] = 8'h09; ld_bytes[43] = 8'h4a;
  endtask

  task automatic load_block(input int gap_a, input int gap_b);
    ref_block_push();
    for (int i = 0; i < 48; i++) begin
      if (i == gap_a || i == gap_b) begin
        in_valid = 1'b0;
        @(negedge clk);
        chk("gap_no_write", core_write, 0);
        tick();
      end
      in_valid = 1'b1;
      in_data  = ld_bytes[i];
      @(negedge clk);
      chk("load_ready", in_ready, 1);
      chk("load_write", core_write, 1);
      chk("load_addr", core_addr, 16 + i);
      chk("load_wdata", core_wdata, ld_bytes[i]);
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Starts in cycle T+1, ends in the first OUT cycle.
  task automatic check_rounds();
    int n_rs, off;
    bit found;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("pat_calc", core_calc, pat_calc[k]);
      chk("pat_shift", core_shift, 1 - pat_calc[k]);
      chk("pat_step", core_step, pat_step[k]);
      chk("pat_busy", busy, 1);
      tick();
    end
    n_rs = 20; off = 21; found = 0;
    while (!found && off < 400) begin
      @(negedge clk);
      if (core_write + core_calc + core_shift + core_add_back > 1)
        chk("strobe_exclusive", 0, 1);
      if (core_add_back) begin
        found = 1;
        chk("add_back_cycle", off, 10 * ROUNDS + 1);
        chk("round_strobes", n_rs, 10 * ROUNDS);
      end else if (core_calc || core_shift) begin
        n_rs++;
      end
      tick();
      off++;
    end
    chk("add_back_seen", found, 1);
  endtask

  task automatic drain(input bit rnd, input bit cmp_rfc);
    int hs, cyc;
    bit stalled;
    logic [7:0] held, want;
    hs = 0; cyc = 0; stalled = 0; held = '0;
    while (hs < 64 && cyc < 1000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      chk("out_valid", out_valid, 1);
      if (cyc == 0) chk("out_busy_low", busy, 0);
      if (stalled) chk("stall_hold", out_data, held);
      if (out_ready) begin
        want = exp_q.pop_front();
        chk("out_data", out_data, want);
        if (cmp_rfc && hs < 16) chk("rfc_byte", out_data, rfc16[hs]);
        hs++;
        stalled = 0;
      end else begin
        stalled = 1;
        held    = out_data;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    chk("handshakes", hs, 64);
    @(negedge clk);
    chk("post_in_ready", in_ready, 1);
    chk("post_out_valid", out_valid, 0);
    tick();
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_strobes"}, {core_write, core_calc, core_shift, core_add_back}, 0);
    chk({tag, "_step"}, core_step, 0);
    chk({tag, "_addr"}, core_addr, 16);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    check_idle("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Counting pattern with input gaps, full-rate drain.
    for (int i = 0; i < 48; i++) ld_bytes[i] = 8'(i);
    load_block(5, 30);
    check_rounds();
    drain(1'b0, 1'b0);

    // Test vector with random back-pressure.
    set_rfc_vector();
    load_block(-1, -1);
    check_rounds();
    drain(1'b1, 1'b1);

    // Reset in the middle of the rounds, then a clean block.
    set_rfc_vector();
    load_block(-1, -1);
    repeat (99) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    check_idle("midreset");
    tick();
    load_block(-1, -1);
    check_rounds();
    drain(1'b0, 1'b1);

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
